reqack_fifo_source: RTL and testbench



---
 rtl/reqack_fifo_source.sv | 113 +++++++++++
 tb/tb_reqack_fifo_source.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/reqack_fifo_source.sv
`default_nettype none
// ============================================================================
// reqack_fifo_source : FIFO-buffered responder for the req/ack pull protocol.
// Optional same-cycle empty bypass when REQACK_FIFO_SOURCE_BYPASS_EN is defined.
// Revision: 1.0
// ============================================================================
module reqack_fifo_source #(
  parameter int data_width  = 32,
  parameter int depth       = 8,
  parameter int output_size = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [data_width-1:0]     in_data,
  input  logic [output_size-1:0]    req,
  output logic                      ack,
  output logic [data_width-1:0]     dout,
  output logic [31:0]               count,
  output logic [$clog2(depth):0]    level
);

  localparam int c_AW = $clog2(depth);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [c_AW:0]         wr_ptr_q, wr_ptr_d;
  logic [c_AW:0]         rd_ptr_q, rd_ptr_d;
  logic [data_width-1:0] dout_q, dout_d;
  logic [31:0]           count_q, count_d;
  logic [data_width-1:0] mem_q [0:depth-1];

  logic w_empty;
  logic w_full;
  logic w_all_req;
  logic w_push;
  logic w_bypass;
  logic w_wr_en;

  assign w_empty   = (wr_ptr_q == rd_ptr_q);
  assign w_full    = (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]) &&
                     (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]);
  assign w_all_req = &req;
  assign w_push    = in_valid & ~w_full;

`ifdef REQACK_FIFO_SOURCE_BYPASS_EN
  // Only legal while empty, so the bypassed word cannot overtake a buffered one.
  assign w_bypass  = w_empty & in_valid & w_all_req & (state_q == S_IDLE);
`else
  assign w_bypass  = 1'b0;
`endif

  assign w_wr_en   = w_push & ~w_bypass;

  always_comb begin
    state_d  = S_IDLE;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    dout_d   = dout_q;
    count_d  = count_q;
    if (state_q == S_IDLE) begin
      if (w_bypass) begin
        state_d = S_GRANT;
        dout_d  = in_data;
        count_d = count_q + 32'd1;
      end else if (w_all_req && !w_empty) begin
        state_d  = S_GRANT;
        dout_d   = mem_q[rd_ptr_q[c_AW-1:0]];
        rd_ptr_d = rd_ptr_q + (c_AW+1)'(1);
        count_d  = count_q + 32'd1;
      end
    end
    if (w_wr_en) begin
      wr_ptr_d = wr_ptr_q + (c_AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem_q[wr_ptr_q[c_AW-1:0]] <= in_data;
    end
  end

  assign ack      = (state_q == S_GRANT);
  assign dout     = dout_q;
  assign count    = count_q;
  assign level    = wr_ptr_q - rd_ptr_q;
  assign in_ready = ~w_full;

endmodule
`default_nettype wire

// File: tb/tb_reqack_fifo_source.sv
`default_nettype none
// ============================================================================
// tb_reqack_fifo_source : directed self-checking bench for reqack_fifo_source.
// Revision: 1.0
// ============================================================================
module tb_reqack_fifo_source;

`ifdef REQACK_FIFO_SOURCE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  // instance A: 32-bit, depth 8, single requester
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [0:0]  req;
  logic        ack;
  logic [31:0] dout;
  logic [31:0] count;
  logic [3:0]  level;
  // instance B: 8-bit, depth 4, three requesters
  logic        in_valid_b;
  logic        in_ready_b;
  logic [7:0]  in_data_b;
  logic [2:0]  req_b;
  logic        ack_b;
  logic [7:0]  dout_b;
  logic [31:0] count_b;
  logic [2:0]  level_b;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  reqack_fifo_source #(.data_width(32), .depth(8), .output_size(1)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .req(req), .ack(ack), .dout(dout),
    .count(count), .level(level)
  );

  reqack_fifo_source #(.data_width(8), .depth(4), .output_size(3)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .req(req_b), .ack(ack_b), .dout(dout_b),
    .count(count_b), .level(level_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_a();
    check("rst_ack",   ack, 0);
    check("rst_dout",  dout, 0);
    check("rst_count", count, 0);
    check("rst_level", level, 0);
    check("rst_ready", in_ready, 1);
  endtask

  initial begin
    int  nxt;
    int  acks;
    bit  acc;
    bit  prev_ack;

    // reset held two cycles with traffic present
    rst = 1'b1; in_valid = 1'b1; in_data = 32'd99; req = 1'b1;
    in_valid_b = 1'b0; in_data_b = 8'h00; req_b = 3'b000;
    tick(); check_reset_a();
    tick(); check_reset_a();
    check("rst_b_level", level_b, 0);

    // ordered stream 0..19 with req held high
    rst = 1'b0; in_valid = 1'b1; in_data = 32'd0; req = 1'b1;
    nxt = 0; acks = 0; prev_ack = 1'b0;
    for (int cyc = 0; cyc < 100 && acks < 20; cyc++) begin
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        nxt++;
        if (nxt == 20) in_valid = 1'b0;
        else in_data = nxt;
      end
      if (ack) begin
        check("stream_dout", dout, acks);
        check("stream_b2b", prev_ack, 0);
        acks++;
      end
      prev_ack = ack;
    end
    check("stream_acks", acks, 20);
    check("stream_count", count, 20);

    // fill and drain: 10 offered, 8 accepted while req is low
    rst = 1'b1; in_valid = 1'b0; req = 1'b0;
    tick();
    rst = 1'b0; nxt = 0; in_valid = 1'b1; in_data = 32'd0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      acc = in_valid && in_ready;
      tick();
      if (acc) begin nxt++; in_data = nxt; end
      check("fill_noack", ack, 0);
    end
    check("fill_level", level, 8);
    check("fill_ready", in_ready, 0);
    check("fill_accepted", nxt, 8);
    req = 1'b1; acks = 0;
    for (int cyc = 0; cyc < 60 && acks < 10; cyc++) begin
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        nxt++;
        if (nxt == 10) in_valid = 1'b0;
        else in_data = nxt;
      end
      if (ack) begin
        check("drain_dout", dout, acks);
        acks++;
      end
    end
    check("drain_acks", acks, 10);
    check("drain_count", count, 10);
    check("drain_level", level, 0);

    // reset during an ack with five words still buffered
    rst = 1'b1; req = 1'b0; in_valid = 1'b0;
    tick();
    rst = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 32'd100 + i;
      tick();
    end
    in_valid = 1'b0;
    check("mid_level6", level, 6);
    req = 1'b1;
    tick();
    check("mid_ack", ack, 1);
    check("mid_dout", dout, 100);
    check("mid_level5", level, 5);
    rst = 1'b1;
    tick();
    check_reset_a();
    rst = 1'b0; in_valid = 1'b1; in_data = 32'd42;
    tick();
    in_valid = 1'b0;
    check("post_first_ack", ack, BYP);
    if (!ack) tick();
    check("post_ack", ack, 1);
    check("post_dout", dout, 42);
    check("post_count", count, 1);
    check("post_level", level, 0);

    // latency from empty: same edge with bypass, one edge later without
    req = 1'b0;
    tick(); tick();
    check("byp_idle", ack, 0);
    req = 1'b1; in_valid = 1'b1; in_data = 32'd7;
    tick();
    in_valid = 1'b0;
    check("byp_ack_edge_k", ack, BYP);
    check("byp_level_k", level, BYP ? 0 : 1);
    if (!ack) tick();
    check("byp_ack", ack, 1);
    check("byp_dout", dout, 7);
    check("byp_count", count, 2);
    check("byp_level", level, 0);
    req = 1'b0;

    // multi-requester: partial request never serves
    req_b = 3'b101; in_valid_b = 1'b1;
    in_data_b = 8'hA1; tick(); check("multi_noack0", ack_b, 0);
    in_data_b = 8'hA2; tick(); check("multi_noack1", ack_b, 0);
    in_valid_b = 1'b0;
    tick();
    check("multi_noack2", ack_b, 0);
    check("multi_level", level_b, 2);
    req_b = 3'b111;
    tick();
    check("multi_ack", ack_b, 1);
    check("multi_dout", dout_b, 8'hA1);
    check("multi_count", count_b, 1);
    tick();
    check("multi_gap", ack_b, 0);
    tick();
    check("multi_ack2", ack_b, 1);
    check("multi_dout2", dout_b, 8'hA2);
    check("multi_level0", level_b, 0);
    req_b = 3'b000;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
